// File: rtl/marsohod2_key_debounce.sv
// Push-button conditioner: per-channel synchronizer, debounce FSM, long-press
// detection and software-cleared sticky event flags for the SoC gpio inputs.
module marsohod2_key_debounce #(
  parameter int NUM_KEYS        = 2,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int LONG_CYCLES     = 24000000,
  parameter int CNT_W           = 25
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_i,
  input  logic [NUM_KEYS-1:0] clr_i,
  output logic [NUM_KEYS-1:0] level_o,
  output logic [NUM_KEYS-1:0] press_o,
  output logic [NUM_KEYS-1:0] release_o,
  output logic [NUM_KEYS-1:0] long_o,
  output logic [NUM_KEYS-1:0] press_flag_o,
  output logic [NUM_KEYS-1:0] long_flag_o
);

  typedef enum logic [1:0] {IDLE, DEB_P, PRESSED, DEB_R} state_t;

  localparam logic IDLE_LVL = ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam bit SKIP_DEB = (DEBOUNCE_CYCLES <= 1);
  localparam bit LONG_EN = (LONG_CYCLES != 0);
  // The state-entry sample counts as the first stable cycle, hence the -2.
  localparam logic [CNT_W-1:0] DEB_LAST = (DEBOUNCE_CYCLES >= 2) ? CNT_W'(DEBOUNCE_CYCLES - 2) : '0;
  localparam logic [CNT_W-1:0] LONG_LAST = (LONG_CYCLES >= 1) ? CNT_W'(LONG_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : gen_ch
    logic sync1, sync2, pressed;
    state_t state, state_nx;
    logic [CNT_W-1:0] dcnt, dcnt_nx, hcnt, hcnt_nx;
    logic long_done, long_done_nx;
    logic press_ev, release_ev, long_ev;
    logic press_q, release_q, long_q;
    logic level_r, press_r, release_r, long_r, press_flag_r, long_flag_r;

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        sync1     <= IDLE_LVL;
        sync2     <= IDLE_LVL;
        pressed   <= 1'b0;
        state     <= IDLE;
        dcnt      <= '0;
        hcnt      <= '0;
        long_done <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        sync1     <= key_i[g];
        sync2     <= sync1;
        pressed   <= sync2 ^ IDLE_LVL;
        state     <= state_nx;
        dcnt      <= dcnt_nx;
        hcnt      <= hcnt_nx;
        long_done <= long_done_nx;
        press_q   <= press_ev;
        release_q <= release_ev;
        long_q    <= long_ev;
      end
    end

    always_comb begin
      state_nx     = state;
      dcnt_nx      = dcnt;
      hcnt_nx      = hcnt;
      long_done_nx = long_done;
      press_ev     = 1'b0;
      release_ev   = 1'b0;
      long_ev      = 1'b0;
      case (state)
        IDLE: begin
          if (pressed) begin
            if (SKIP_DEB) begin
              state_nx     = PRESSED;
              press_ev     = 1'b1;
              hcnt_nx      = '0;
              long_done_nx = 1'b0;
            end else begin
              state_nx = DEB_P;
              dcnt_nx  = '0;
            end
          end
        end
        DEB_P: begin
          if (!pressed) begin
            state_nx = IDLE;
          end else if (dcnt >= DEB_LAST) begin
            state_nx     = PRESSED;
            press_ev     = 1'b1;
            hcnt_nx      = '0;
            long_done_nx = 1'b0;
          end else begin
            dcnt_nx = dcnt + 1'b1;
          end
        end
        PRESSED: begin
          if (hcnt < LONG_MAX) hcnt_nx = hcnt + 1'b1;
          // Without a debounce window a release could land on the long edge.
          if (LONG_EN && !long_done && hcnt == LONG_LAST && !(SKIP_DEB && !pressed)) begin
            long_ev      = 1'b1;
            long_done_nx = 1'b1;
          end
          if (!pressed) begin
            if (SKIP_DEB) begin
              state_nx   = IDLE;
              release_ev = 1'b1;
            end else begin
              state_nx = DEB_R;
              dcnt_nx  = '0;
            end
          end
        end
        DEB_R: begin
          if (pressed) begin
            state_nx = PRESSED;
          end else if (dcnt >= DEB_LAST) begin
            state_nx   = IDLE;
            release_ev = 1'b1;
          end else begin
            dcnt_nx = dcnt + 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    // Sticky flags take the registered pulse, so a clear in the pulse cycle loses.
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        level_r      <= 1'b0;
        press_r      <= 1'b0;
        release_r    <= 1'b0;
        long_r       <= 1'b0;
        press_flag_r <= 1'b0;
        long_flag_r  <= 1'b0;
      end else begin
        level_r      <= (state == PRESSED) || (state == DEB_R);
        press_r      <= press_q;
        release_r    <= release_q;
        long_r       <= long_q;
        press_flag_r <= press_r | (press_flag_r & ~clr_i[g]);
        long_flag_r  <= long_r | (long_flag_r & ~clr_i[g]);
      end
    end

    assign level_o[g]      = level_r;
    assign press_o[g]      = press_r;
    assign release_o[g]    = release_r;
    assign long_o[g]       = long_r;
    assign press_flag_o[g] = press_flag_r;
    assign long_flag_o[g]  = long_flag_r;
  end

endmodule

// File: tb/tb_marsohod2_key_debounce.sv
// Scoreboard bench for marsohod2_key_debounce: stimulus queues expected pulses,
// a negedge monitor pops and matches them against press/release/long outputs.
module tb_marsohod2_key_debounce;

  localparam int NK = 2;
  localparam int K_PRESS = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG = 2;

  logic clock = 1'b0;
  logic reset_n;
  logic [NK-1:0] key_i, clr_i;
  logic [NK-1:0] level_o, press_o, release_o, long_o, press_flag_o, long_flag_o;
  logic [6*NK-1:0] all_outs;

  typedef struct {
    int kind;
    int ch;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int c;
  bit mon_en = 1'b0;

  marsohod2_key_debounce #(
    .NUM_KEYS(NK),
    .ACTIVE_LOW(1'b1),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(10),
    .CNT_W(25)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .key_i(key_i),
    .clr_i(clr_i),
    .level_o(level_o),
    .press_o(press_o),
    .release_o(release_o),
    .long_o(long_o),
    .press_flag_o(press_flag_o),
    .long_flag_o(long_flag_o)
  );

  assign all_outs = {level_o, press_o, release_o, long_o, press_flag_o, long_flag_o};

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task expectEvent(input int kind, input int ch, input int at);
    ev_t e;
    e.kind = kind;
    e.ch = ch;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  task applyStimulus(input logic [NK-1:0] key, input logic [NK-1:0] clr);
    key_i = key;
    clr_i = clr;
  endtask

  task step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Every pulse seen must match the oldest outstanding expectation exactly.
  always @(negedge clock) begin
    if (mon_en) begin
      for (int ch = 0; ch < NK; ch++) begin
        for (int k = 0; k < 3; k++) begin
          logic hit;
          ev_t e;
          hit = (k == K_PRESS) ? press_o[ch] : (k == K_RELEASE) ? release_o[ch] : long_o[ch];
          if (hit === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("[TB] FAIL unexpected_event: got kind=%0d ch=%0d cycle=%0d, expected none", k, ch, cyc);
            end else begin
              e = exp_q.pop_front();
              if (e.kind != k || e.ch != ch || e.cyc != cyc) begin
                errors++;
                $display("[TB] FAIL event_match: got kind=%0d ch=%0d cycle=%0d, expected kind=%0d ch=%0d cycle=%0d",
                         k, ch, cyc, e.kind, e.ch, e.cyc);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    applyStimulus(2'b11, 2'b00);
    step(3);
    mon_en = 1'b1;
    checkOutput("reset_outputs", 32'(all_outs), 32'd0);
    reset_n = 1'b1;

    // Idle after reset: nothing may move.
    for (int i = 0; i < 20; i++) begin
      step(1);
      checkOutput("idle_outputs", 32'(all_outs), 32'd0);
    end

    // Long hold on key 0, then release.
    c = cyc;
    applyStimulus(2'b10, 2'b00);
    expectEvent(K_PRESS, 0, c + 8);
    expectEvent(K_LONG, 0, c + 18);
    step(7);
    checkOutput("level_before_press", 32'(level_o), 32'd0);
    step(1);
    checkOutput("level_after_press", 32'(level_o), 32'd1);
    step(1);
    checkOutput("press_flag_set", 32'(press_flag_o), 32'd1);
    step(10);
    checkOutput("long_flag_set", 32'(long_flag_o), 32'd1);
    step(21);
    c = cyc;
    applyStimulus(2'b11, 2'b00);
    expectEvent(K_RELEASE, 0, c + 8);
    step(7);
    checkOutput("level_before_release", 32'(level_o), 32'd1);
    step(1);
    checkOutput("level_after_release", 32'(level_o), 32'd0);
    applyStimulus(2'b11, 2'b01);
    step(1);
    applyStimulus(2'b11, 2'b00);
    checkOutput("flags_cleared", 32'({press_flag_o, long_flag_o}), 32'd0);
    step(5);

    // Three-cycle glitch is dropped; four-cycle press on key 1 is accepted.
    applyStimulus(2'b10, 2'b00);
    step(3);
    applyStimulus(2'b11, 2'b00);
    step(12);
    checkOutput("glitch_level", 32'(level_o), 32'd0);
    checkOutput("glitch_flags", 32'(press_flag_o), 32'd0);
    c = cyc;
    applyStimulus(2'b01, 2'b00);
    expectEvent(K_PRESS, 1, c + 8);
    expectEvent(K_RELEASE, 1, c + 12);
    step(4);
    applyStimulus(2'b11, 2'b00);
    step(4);
    checkOutput("k1_level_on", 32'(level_o), 32'd2);
    step(4);
    checkOutput("k1_level_off", 32'(level_o), 32'd0);
    step(4);
    checkOutput("k1_press_flag", 32'(press_flag_o), 32'd2);

    // Release bounce during a held press is absorbed.
    c = cyc;
    applyStimulus(2'b10, 2'b00);
    expectEvent(K_PRESS, 0, c + 8);
    expectEvent(K_LONG, 0, c + 18);
    step(25);
    applyStimulus(2'b11, 2'b00);
    step(2);
    applyStimulus(2'b10, 2'b00);
    for (int i = 0; i < 15; i++) begin
      step(1);
      checkOutput("bounce_level", 32'(level_o), 32'd1);
    end
    step(8);
    c = cyc;
    applyStimulus(2'b11, 2'b00);
    expectEvent(K_RELEASE, 0, c + 8);
    step(15);

    // Set beats clear in the pulse cycle; a later clear wins; channel 1 untouched.
    applyStimulus(2'b11, 2'b01);
    step(1);
    applyStimulus(2'b11, 2'b00);
    checkOutput("pre_clear_press", 32'(press_flag_o), 32'd2);
    checkOutput("pre_clear_long", 32'(long_flag_o), 32'd0);
    c = cyc;
    applyStimulus(2'b10, 2'b00);
    expectEvent(K_PRESS, 0, c + 8);
    expectEvent(K_LONG, 0, c + 18);
    step(8);
    applyStimulus(2'b10, 2'b01);
    step(1);
    checkOutput("set_wins_clear", 32'(press_flag_o), 32'd3);
    step(1);
    applyStimulus(2'b10, 2'b00);
    checkOutput("clear_after_set", 32'(press_flag_o), 32'd2);
    step(10);
    checkOutput("long_flag_again", 32'(long_flag_o), 32'd1);
    c = cyc;
    applyStimulus(2'b11, 2'b00);
    expectEvent(K_RELEASE, 0, c + 8);
    step(12);

    // Reset while pressed aborts silently; held key re-detected afterwards.
    c = cyc;
    applyStimulus(2'b10, 2'b00);
    expectEvent(K_PRESS, 0, c + 8);
    step(12);
    checkOutput("pre_reset_level", 32'(level_o), 32'd1);
    reset_n = 1'b0;
    step(1);
    checkOutput("reset_abort_outs", 32'(all_outs), 32'd0);
    step(1);
    reset_n = 1'b1;
    c = cyc;
    expectEvent(K_PRESS, 0, c + 8);
    expectEvent(K_LONG, 0, c + 18);
    step(7);
    checkOutput("post_reset_level_low", 32'(level_o), 32'd0);
    step(1);
    checkOutput("post_reset_level_high", 32'(level_o), 32'd1);
    step(13);
    c = cyc;
    applyStimulus(2'b11, 2'b00);
    expectEvent(K_RELEASE, 0, c + 8);
    step(15);

    // Both channels together.
    c = cyc;
    applyStimulus(2'b00, 2'b00);
    expectEvent(K_PRESS, 0, c + 8);
    expectEvent(K_PRESS, 1, c + 8);
    expectEvent(K_LONG, 0, c + 18);
    expectEvent(K_LONG, 1, c + 18);
    step(8);
    checkOutput("both_level", 32'(level_o), 32'd3);
    step(17);
    c = cyc;
    applyStimulus(2'b11, 2'b00);
    expectEvent(K_RELEASE, 0, c + 8);
    expectEvent(K_RELEASE, 1, c + 8);
    step(15);
    checkOutput("both_level_off", 32'(level_o), 32'd0);

    step(5);
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    foreach (exp_q[i])
      $display("[TB] pending kind=%0d ch=%0d cycle=%0d", exp_q[i].kind, exp_q[i].ch, exp_q[i].cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
